// File: rtl/carregador_uart.sv
// UART bootloader: receives a length-prefixed image over 8N1 serial and writes 32-bit words into instruction memory.
// Optional inter-byte timeout enabled by defining CARREGADOR_TIMEOUT_EN.
module carregador_uart #(
  parameter int CLK_FREQ       = 50000000,
  parameter int BAUD           = 115200,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CICLOS = 5000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx,
  output logic              mem_escrever,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [31:0]       mem_dado,
  output logic              carregando,
  output logic              pronto,
  output logic              erro_quadro
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_CAB0  = 3'd0;
  localparam logic [2:0] LD_CAB1  = 3'd1;
  localparam logic [2:0] LD_DADOS = 3'd2;
  localparam logic [2:0] LD_FIM   = 3'd3;
  localparam logic [2:0] LD_ERRO  = 3'd4;

  logic             r_rx_s1, r_rx_s2;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;
  logic [1:0]       r_rx_state;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_byte_ok, r_byte_err;

  logic [2:0]       r_ld_state;
  logic [15:0]      r_n;
  logic [15:0]      r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_word;
  logic             r_mem_escrever;
  logic [ADDR_W-1:0] r_mem_endereco;
  logic [31:0]      r_mem_dado;
  logic             r_carregando, r_pronto, r_erro;
  logic             w_in_range;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_div_cnt <= '0;
    else          r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
  end

  // Receiver: start bit checked at mid-bit (8th tick), then every 16 ticks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= RX_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte_ok  <= 1'b0;
      r_byte_err <= 1'b0;
    end else begin
      r_byte_ok  <= 1'b0;
      r_byte_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s2) begin
            r_rx_state <= RX_START;
            r_tick_cnt <= '0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd7) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_shift <= {r_rx_s2, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) r_rx_state <= RX_STOP;
              else                   r_bit_cnt  <= r_bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_byte_ok  <= r_rx_s2;
              r_byte_err <= !r_rx_s2;
              r_rx_state <= RX_IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef CARREGADOR_TIMEOUT_EN
  logic [31:0] r_gap;
  logic        w_aguarda;
  logic        w_timeout;

  assign w_aguarda = (r_ld_state == LD_CAB1) || (r_ld_state == LD_DADOS);
  assign w_timeout = w_aguarda && !r_byte_ok && (r_gap == 32'(TIMEOUT_CICLOS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             r_gap <= '0;
    else if (r_byte_ok || w_timeout || !w_aguarda) r_gap <= '0;
    else                                      r_gap <= r_gap + 32'd1;
  end
`endif

  // Words past the end of memory are consumed but never written (no address wrap).
  assign w_in_range = ({1'b0, r_word_idx} < (17'd1 << ADDR_W));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ld_state     <= LD_CAB0;
      r_n            <= '0;
      r_word_idx     <= '0;
      r_byte_idx     <= '0;
      r_word         <= '0;
      r_mem_escrever <= 1'b0;
      r_mem_endereco <= '0;
      r_mem_dado     <= '0;
      r_carregando   <= 1'b1;
      r_pronto       <= 1'b0;
      r_erro         <= 1'b0;
    end else begin
      r_mem_escrever <= 1'b0;
      case (r_ld_state)
        LD_CAB0: begin
          if (r_byte_err) begin
            r_ld_state <= LD_ERRO;
            r_erro     <= 1'b1;
          end else if (r_byte_ok) begin
            r_n[7:0]   <= r_shift;
            r_ld_state <= LD_CAB1;
          end
        end
        LD_CAB1: begin
          if (r_byte_err) begin
            r_ld_state <= LD_ERRO;
            r_erro     <= 1'b1;
          end else if (r_byte_ok) begin
            r_n[15:8] <= r_shift;
            if ({r_shift, r_n[7:0]} == 16'd0) begin
              r_ld_state   <= LD_FIM;
              r_pronto     <= 1'b1;
              r_carregando <= 1'b0;
            end else begin
              r_ld_state <= LD_DADOS;
              r_word_idx <= '0;
              r_byte_idx <= '0;
            end
          end
`ifdef CARREGADOR_TIMEOUT_EN
          else if (w_timeout) begin
            r_ld_state <= LD_CAB0;
            r_n        <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
`endif
        end
        LD_DADOS: begin
          if (r_byte_err) begin
            r_ld_state <= LD_ERRO;
            r_erro     <= 1'b1;
          end else if (r_byte_ok) begin
            r_word     <= {r_word[15:0], r_shift};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              if (w_in_range) begin
                r_mem_escrever <= 1'b1;
                r_mem_endereco <= r_word_idx[ADDR_W-1:0];
                r_mem_dado     <= {r_word, r_shift};
              end
              r_word_idx <= r_word_idx + 16'd1;
              if (r_word_idx == r_n - 16'd1) begin
                r_ld_state   <= LD_FIM;
                r_pronto     <= 1'b1;
                r_carregando <= 1'b0;
              end
            end
          end
`ifdef CARREGADOR_TIMEOUT_EN
          else if (w_timeout) begin
            r_ld_state <= LD_CAB0;
            r_n        <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign mem_escrever = r_mem_escrever;
  assign mem_endereco = r_mem_endereco;
  assign mem_dado     = r_mem_dado;
  assign carregando   = r_carregando;
  assign pronto       = r_pronto;
  assign erro_quadro  = r_erro;

endmodule

// File: tb/tb_carregador_uart.sv
// Directed bench for carregador_uart: table of serial images with expected strobes, plus glitch and reset sequences.
module tb_carregador_uart;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          mem_escrever;
  logic [AW-1:0] mem_endereco;
  logic [31:0]   mem_dado;
  logic          carregando, pronto, erro_quadro;

  always #5 clock = ~clock;

  carregador_uart #(
    .CLK_FREQ(1600000), .BAUD(100000), .ADDR_W(AW), .TIMEOUT_CICLOS(1000)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rx(rx),
    .mem_escrever(mem_escrever), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
    .carregando(carregando), .pronto(pronto), .erro_quadro(erro_quadro)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_str   = 0;
  logic [31:0]   log_dado [0:63];
  logic [AW-1:0] log_addr [0:63];
  logic          log_pr   [0:63];
  logic          log_ca   [0:63];

  always @(negedge clock) begin
    if (mem_escrever) begin
      log_dado[n_str & 63] = mem_dado;
      log_addr[n_str & 63] = mem_endereco;
      log_pr[n_str & 63]   = pronto;
      log_ca[n_str & 63]   = carregando;
      n_str = n_str + 1;
    end
  end

  typedef struct packed {
    logic [191:0] s;       // byte stream, first byte in the most significant used position
    logic [4:0]   nb;
    logic [4:0]   bad;     // index of byte sent with stop bit 0 (31 = none)
    logic [4:0]   gap_at;  // 1200 idle clocks after this byte (31 = none)
    logic [2:0]   nstr;
    logic [127:0] w;       // expected words, first one most significant
    logic         last_pr; // pronto expected on the final strobe
    logic         pr, ca, er;
  } vec_t;

  vec_t tv [0:5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clock);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clock);
    end
    rx = stop_ok;
    repeat (16) @(negedge clock);
    rx = 1'b1;
    if (!stop_ok) repeat (200) @(negedge clock);
    else          repeat (4) @(negedge clock);
  endtask

  task automatic send_stream(input logic [191:0] s, input int nb);
    for (int k = 0; k < nb; k++) send_byte(s[8*(nb-1-k) +: 8], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_escrever", {31'd0, mem_escrever}, 32'd0);
    chk("rst_endereco", {{(32-AW){1'b0}}, mem_endereco}, 32'd0);
    chk("rst_dado", mem_dado, 32'd0);
    chk("rst_carregando", {31'd0, carregando}, 32'd1);
    chk("rst_pronto", {31'd0, pronto}, 32'd0);
    chk("rst_erro", {31'd0, erro_quadro}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int base;
    int idx;
    tv[0] = '{s:192'h02_00_20_08_00_05_8C_09_00_04, nb:10, bad:31, gap_at:31, nstr:2,
              w:128'h20080005_8C090004, last_pr:1, pr:1, ca:0, er:0};
    tv[1] = '{s:192'h00_00_FF, nb:3, bad:31, gap_at:31, nstr:0,
              w:128'h0, last_pr:0, pr:1, ca:0, er:0};
    tv[2] = '{s:192'h01_00_AA_55_11_22_33_44, nb:8, bad:3, gap_at:31, nstr:0,
              w:128'h0, last_pr:0, pr:0, ca:1, er:1};
    tv[3] = '{s:192'h05_00_11111111_22222222_33333333_44444444_55555555, nb:22, bad:31, gap_at:31,
              nstr:4, w:128'h11111111_22222222_33333333_44444444, last_pr:0, pr:1, ca:0, er:0};
    tv[4] = '{s:192'h01_00_CA_FE_BA_BE_99_88_77_66, nb:10, bad:31, gap_at:31, nstr:1,
              w:128'hCAFEBABE, last_pr:1, pr:1, ca:0, er:0};
`ifdef CARREGADOR_TIMEOUT_EN
    tv[5] = '{s:192'h01_00_AB_01_00_12_34_56_78, nb:9, bad:31, gap_at:2, nstr:1,
              w:128'h12345678, last_pr:1, pr:1, ca:0, er:0};
`else
    tv[5] = '{s:192'h01_00_AB_01_00_12_34_56_78, nb:9, bad:31, gap_at:2, nstr:1,
              w:128'hAB010012, last_pr:1, pr:1, ca:0, er:0};
`endif

    for (int v = 0; v < 6; v++) begin
      do_reset();
      base = n_str;
      for (int k = 0; k < int'(tv[v].nb); k++) begin
        send_byte(tv[v].s[8*(int'(tv[v].nb)-1-k) +: 8], k != int'(tv[v].bad));
        if (k == int'(tv[v].gap_at)) repeat (1200) @(negedge clock);
      end
      repeat (300) @(negedge clock);
      chk($sformatf("v%0d_strobes", v), n_str - base, {29'd0, tv[v].nstr});
      for (int i = 0; i < int'(tv[v].nstr); i++) begin
        idx = (base + i) & 63;
        chk($sformatf("v%0d_addr%0d", v, i), {{(32-AW){1'b0}}, log_addr[idx]}, i);
        chk($sformatf("v%0d_dado%0d", v, i), log_dado[idx],
            tv[v].w[32*(int'(tv[v].nstr)-1-i) +: 32]);
        chk($sformatf("v%0d_pr_at%0d", v, i), {31'd0, log_pr[idx]},
            {31'd0, tv[v].last_pr && (i == int'(tv[v].nstr) - 1)});
        chk($sformatf("v%0d_ca_at%0d", v, i), {31'd0, log_ca[idx]},
            {31'd0, !(tv[v].last_pr && (i == int'(tv[v].nstr) - 1))});
      end
      chk($sformatf("v%0d_pronto", v), {31'd0, pronto}, {31'd0, tv[v].pr});
      chk($sformatf("v%0d_carregando", v), {31'd0, carregando}, {31'd0, tv[v].ca});
      chk($sformatf("v%0d_erro", v), {31'd0, erro_quadro}, {31'd0, tv[v].er});
    end

    // Start glitch shorter than half a bit must not produce a byte.
    do_reset();
    base = n_str;
    @(negedge clock);
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (100) @(negedge clock);
    chk("glitch_nostrobe", n_str - base, 32'd0);
    send_stream(192'h01_00_00_00_00_2A, 6);
    repeat (300) @(negedge clock);
    chk("glitch_strobes", n_str - base, 32'd1);
    chk("glitch_addr", {{(32-AW){1'b0}}, log_addr[base & 63]}, 32'd0);
    chk("glitch_dado", log_dado[base & 63], 32'h0000002A);
    chk("glitch_pronto", {31'd0, pronto}, 32'd1);

    // Reset in the middle of a word discards the partial image.
    do_reset();
    base = n_str;
    send_stream(192'h02_00_11_22, 4);
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk("midrst_nostrobe", n_str - base, 32'd0);
    send_stream(192'h01_00_DE_AD_BE_EF, 6);
    repeat (300) @(negedge clock);
    chk("midrst_strobes", n_str - base, 32'd1);
    chk("midrst_addr", {{(32-AW){1'b0}}, log_addr[base & 63]}, 32'd0);
    chk("midrst_dado", log_dado[base & 63], 32'hDEADBEEF);
    chk("midrst_pronto", {31'd0, pronto}, 32'd1);
    chk("midrst_carregando", {31'd0, carregando}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
